// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Round-robin sharing of one line-wide memory port between the
//            I-cache and the D-cache, with per-client completion counters.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int WORD_SIZE  = 16,
    parameter int QWORD_SIZE = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    // I-cache client
    input  logic                  i_read_m,
    input  logic                  i_write_m,
    input  logic [WORD_SIZE-1:0]  i_addr,
    input  logic [WORD_SIZE-1:0]  i_size,
    input  logic [QWORD_SIZE-1:0] i_wdata,
    output logic [QWORD_SIZE-1:0] i_rdata,
    output logic                  i_ready,
    // D-cache client
    input  logic                  d_read_m,
    input  logic                  d_write_m,
    input  logic [WORD_SIZE-1:0]  d_addr,
    input  logic [WORD_SIZE-1:0]  d_size,
    input  logic [QWORD_SIZE-1:0] d_wdata,
    output logic [QWORD_SIZE-1:0] d_rdata,
    output logic                  d_ready,
    // Shared memory port
    output logic                  m_read_m,
    output logic                  m_write_m,
    output logic [WORD_SIZE-1:0]  m_addr,
    output logic [WORD_SIZE-1:0]  m_size,
    output logic [QWORD_SIZE-1:0] m_wdata,
    input  logic [QWORD_SIZE-1:0] m_rdata,
    input  logic                  m_ready,
    // Performance counters
    output logic [CNT_WIDTH-1:0]  i_grant_cnt,
    output logic [CNT_WIDTH-1:0]  d_grant_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_last_d;       // 1 when the most recent grant went to the D-cache
    logic   w_i_req;
    logic   w_d_req;
    logic   w_grant_i;
    logic   w_grant_d;
    logic   w_done;

    always_comb begin
        w_i_req     = i_read_m | i_write_m;
        w_d_req     = d_read_m | d_write_m;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        w_done      = 1'b0;
        w_state_nxt = r_state;
        i_ready     = 1'b0;
        d_ready     = 1'b0;
        i_rdata     = '0;
        d_rdata     = '0;
        case (r_state)
            ST_IDLE: begin
                // On a tie the client that did not win last time goes first
                w_grant_d = w_d_req & (~w_i_req | ~r_last_d);
                w_grant_i = w_i_req & ~w_grant_d;
                if (w_grant_d) begin
                    w_state_nxt = ST_BUSY_D;
                end else if (w_grant_i) begin
                    w_state_nxt = ST_BUSY_I;
                end
            end
            ST_BUSY_I: begin
                i_ready = m_ready;
                i_rdata = m_rdata;
                w_done  = m_ready;
                if (m_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY_D: begin
                d_ready = m_ready;
                d_rdata = m_rdata;
                w_done  = m_ready;
                if (m_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_d    <= 1'b0;
            m_read_m    <= 1'b0;
            m_write_m   <= 1'b0;
            m_addr      <= '0;
            m_size      <= '0;
            m_wdata     <= '0;
            i_grant_cnt <= '0;
            d_grant_cnt <= '0;
        end else if (w_grant_d) begin
            // Write takes precedence if a client raises both strobes
            m_addr    <= d_addr;
            m_size    <= d_size;
            m_wdata   <= d_wdata;
            m_write_m <= d_write_m;
            m_read_m  <= d_read_m & ~d_write_m;
            r_last_d  <= 1'b1;
        end else if (w_grant_i) begin
            m_addr    <= i_addr;
            m_size    <= i_size;
            m_wdata   <= i_wdata;
            m_write_m <= i_write_m;
            m_read_m  <= i_read_m & ~i_write_m;
            r_last_d  <= 1'b0;
        end else if (w_done) begin
            m_read_m  <= 1'b0;
            m_write_m <= 1'b0;
            if (r_state == ST_BUSY_I && i_grant_cnt != '1) begin
                i_grant_cnt <= i_grant_cnt + CNT_WIDTH'(1);
            end
            if (r_state == ST_BUSY_D && d_grant_cnt != '1) begin
                d_grant_cnt <= d_grant_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Randomized and directed checking of mem_port_arbiter against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_read_m, i_write_m, i_ready;
    logic [15:0] i_addr, i_size;
    logic [63:0] i_wdata, i_rdata;
    logic        d_read_m, d_write_m, d_ready;
    logic [15:0] d_addr, d_size;
    logic [63:0] d_wdata, d_rdata;
    logic        m_read_m, m_write_m, m_ready;
    logic [15:0] m_addr, m_size;
    logic [63:0] m_wdata, m_rdata;
    logic [15:0] i_grant_cnt, d_grant_cnt;

    // Outputs of the narrow-counter instance
    logic        s_i_ready, s_d_ready, s_m_read_m, s_m_write_m;
    logic [63:0] s_i_rdata, s_d_rdata, s_m_wdata;
    logic [15:0] s_m_addr, s_m_size;
    logic [1:0]  s_i_cnt, s_d_cnt;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .i_read_m(i_read_m), .i_write_m(i_write_m), .i_addr(i_addr), .i_size(i_size),
        .i_wdata(i_wdata), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read_m(d_read_m), .d_write_m(d_write_m), .d_addr(d_addr), .d_size(d_size),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
        .m_read_m(m_read_m), .m_write_m(m_write_m), .m_addr(m_addr), .m_size(m_size),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready),
        .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
    );

    mem_port_arbiter #(.CNT_WIDTH(2)) dut_sat (
        .clk(clk), .reset(reset),
        .i_read_m(i_read_m), .i_write_m(i_write_m), .i_addr(i_addr), .i_size(i_size),
        .i_wdata(i_wdata), .i_rdata(s_i_rdata), .i_ready(s_i_ready),
        .d_read_m(d_read_m), .d_write_m(d_write_m), .d_addr(d_addr), .d_size(d_size),
        .d_wdata(d_wdata), .d_rdata(s_d_rdata), .d_ready(s_d_ready),
        .m_read_m(s_m_read_m), .m_write_m(s_m_write_m), .m_addr(s_m_addr), .m_size(s_m_size),
        .m_wdata(s_m_wdata), .m_rdata(m_rdata), .m_ready(m_ready),
        .i_grant_cnt(s_i_cnt), .d_grant_cnt(s_d_cnt)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: port owner and last winner (0 none, 1 I-cache, 2 D-cache)
    int          own, last;
    logic        exp_rd, exp_wr;
    logic [15:0] exp_addr, exp_size;
    logic [63:0] exp_wdata;
    int          cnt_i, cnt_d;
    logic        seen_i, seen_d, seen_rst;
    int          done_order[$];
    bit          hold_i, hold_d;
    int          mem_wait, mem_lat, cyc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int sat(input int c, input int mx);
        return (c > mx) ? mx : c;
    endfunction

    task automatic model_edge();
        bit ri, rd;
        int win;
        if (reset) begin
            own = 0; last = 1; exp_rd = 0; exp_wr = 0;
            exp_addr = '0; exp_size = '0; exp_wdata = '0; cnt_i = 0; cnt_d = 0;
        end else if (own == 0) begin
            ri  = i_read_m | i_write_m;
            rd  = d_read_m | d_write_m;
            win = (ri && rd) ? 3 - last : (rd ? 2 : (ri ? 1 : 0));
            if (win == 1) begin
                exp_addr = i_addr; exp_size = i_size; exp_wdata = i_wdata;
                exp_wr = i_write_m; exp_rd = i_read_m & ~i_write_m;
            end else if (win == 2) begin
                exp_addr = d_addr; exp_size = d_size; exp_wdata = d_wdata;
                exp_wr = d_write_m; exp_rd = d_read_m & ~d_write_m;
            end
            if (win != 0) begin own = win; last = win; end
        end else if (m_ready) begin
            exp_rd = 0; exp_wr = 0;
            if (own == 1) cnt_i++; else cnt_d++;
            own = 0;
        end
    endtask

    // Compare all outputs for the current cycle, then advance one clock
    task automatic cycle();
        logic ei, ed;
        #1;
        ei = (own == 1) && m_ready;
        ed = (own == 2) && m_ready;
        check("m_read_m", m_read_m, exp_rd);
        check("m_write_m", m_write_m, exp_wr);
        check("m_addr", m_addr, exp_addr);
        check("m_size", m_size, exp_size);
        check("m_wdata", m_wdata, exp_wdata);
        check("i_ready", i_ready, ei);
        check("d_ready", d_ready, ed);
        check("i_rdata", i_rdata, (own == 1) ? m_rdata : 64'd0);
        check("d_rdata", d_rdata, (own == 2) ? m_rdata : 64'd0);
        check("i_grant_cnt", i_grant_cnt, 64'(sat(cnt_i, 65535)));
        check("d_grant_cnt", d_grant_cnt, 64'(sat(cnt_d, 65535)));
        check("sat_i_cnt", s_i_cnt, 64'(sat(cnt_i, 3)));
        check("sat_d_cnt", s_d_cnt, 64'(sat(cnt_d, 3)));
        check("sat_strobes", {s_m_read_m, s_m_write_m}, {exp_rd, exp_wr});
        check("sat_ready", {s_i_ready, s_d_ready}, {ei, ed});
        check("sat_payload", {s_m_addr, s_m_size} ^ s_m_wdata[31:0], {exp_addr, exp_size} ^ exp_wdata[31:0]);
        check("sat_rdata", s_i_rdata ^ s_d_rdata, (own != 0) ? m_rdata : 64'd0);
        if (i_ready) done_order.push_back(1);
        if (d_ready) done_order.push_back(2);
        seen_i = ei; seen_d = ed; seen_rst = reset;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Cache client: holds a request until it sees its ready, drops it after reset
    task automatic agent(input int pct, input logic seen, inout bit hold,
                         inout logic rd, inout logic wr, inout logic [15:0] addr,
                         inout logic [15:0] size, inout logic [63:0] wdata);
        int k;
        if (seen || seen_rst) begin
            hold = 0;
        end else if (!hold) begin
            if (int'($urandom_range(99)) < pct) begin
                hold = 1;
                k  = int'($urandom_range(19));
                wr = (k < 7);
                rd = (k >= 6);
                addr = 16'($urandom); size = 16'($urandom); wdata = {$urandom, $urandom};
            end
        end else if ($urandom_range(3) == 0) begin
            addr = 16'($urandom); size = 16'($urandom); wdata = {$urandom, $urandom};
        end
        if (!hold) begin rd = 0; wr = 0; end
    endtask

    // Memory: random latency on a live strobe, occasional spurious ready when idle
    task automatic mem_agent();
        m_rdata = {$urandom, $urandom};
        if (exp_rd || exp_wr) begin
            mem_wait++;
            if (mem_wait >= mem_lat) begin
                m_ready = 1; mem_wait = 0; mem_lat = int'($urandom_range(5, 1));
            end else begin
                m_ready = 0;
            end
        end else begin
            mem_wait = 0;
            m_ready  = ($urandom_range(7) == 0);
        end
    endtask

    task automatic quiet();
        i_read_m = 0; i_write_m = 0; d_read_m = 0; d_write_m = 0;
        m_ready = 0; m_rdata = '0; hold_i = 0; hold_d = 0;
    endtask

    task automatic d_xact();
        d_read_m = 1; cycle();
        cycle();
        m_ready = 1; cycle();
        d_read_m = 0; m_ready = 0; cycle();
    endtask

    initial begin
        reset = 1; quiet();
        i_addr = '0; i_size = '0; i_wdata = '0; d_addr = '0; d_size = '0; d_wdata = '0;
        mem_wait = 0; mem_lat = 2;
        @(posedge clk); model_edge(); @(negedge clk);
        cycle();
        reset = 0;

        // Single I read with memory answering in cycle 6
        i_read_m = 1; i_addr = 16'h0040; i_size = 16'd64; cycle();
        check("single_strobe", m_read_m, 1'b1);
        check("single_addr", m_addr, 16'h0040);
        repeat (4) cycle();
        m_ready = 1; m_rdata = 64'h1111_2222_3333_4444; cycle();
        i_read_m = 0; m_ready = 0; m_rdata = '0;
        check("single_strobe_off", m_read_m, 1'b0);
        check("single_cnt", i_grant_cnt, 16'd1);
        cycle();

        // D write while the I-cache waits; D payload changes mid-transaction
        d_write_m = 1; d_addr = 16'h0010; d_size = 16'd64; d_wdata = 64'hAAAA_BBBB_CCCC_DDDD; cycle();
        i_read_m = 1; i_addr = 16'h0080; d_wdata = 64'h0; d_addr = 16'hFFFF; cycle();
        check("dw_wdata", m_wdata, 64'hAAAA_BBBB_CCCC_DDDD);
        check("dw_write", m_write_m, 1'b1);
        check("dw_read", m_read_m, 1'b0);
        cycle();
        m_ready = 1; cycle();
        d_write_m = 0; m_ready = 0;
        check("bubble_strobe", m_read_m, 1'b0);
        cycle();
        check("i_after_d_strobe", m_read_m, 1'b1);
        check("i_after_d_addr", m_addr, 16'h0080);
        m_ready = 1; cycle();
        i_read_m = 0; m_ready = 0; cycle();

        // Reset during the second busy cycle aborts the transaction
        i_read_m = 1; i_addr = 16'h0100; cycle();
        cycle();
        reset = 1; cycle();
        reset = 0; i_read_m = 0;
        check("abort_strobe", m_read_m, 1'b0);
        check("abort_cnt", i_grant_cnt, 16'd0);
        cycle();
        i_read_m = 1; cycle();
        m_ready = 1; cycle();
        i_read_m = 0; m_ready = 0; cycle();
        check("after_abort_cnt", i_grant_cnt, 16'd1);

        // Spurious memory ready while idle
        m_ready = 1; repeat (3) cycle();
        m_ready = 0;
        check("spurious_i_cnt", i_grant_cnt, 16'd1);
        check("spurious_d_cnt", d_grant_cnt, 16'd0);

        // Narrow counter saturation
        reset = 1; cycle(); reset = 0;
        repeat (4) d_xact();
        check("sat_d_cnt_final", s_d_cnt, 2'd3);
        check("wide_d_cnt_final", d_grant_cnt, 16'd4);

        // Continuous contention from reset: order must alternate D,I,D,I,D,I
        reset = 1; quiet(); cycle(); reset = 0;
        done_order.delete(); cyc = 0;
        while (done_order.size() < 6 && cyc < 300) begin
            agent(100, seen_i, hold_i, i_read_m, i_write_m, i_addr, i_size, i_wdata);
            agent(100, seen_d, hold_d, d_read_m, d_write_m, d_addr, d_size, d_wdata);
            mem_agent(); cycle(); cyc++;
        end
        check("contend_count", done_order.size(), 6);
        for (int k = 0; k < 6 && k < done_order.size(); k++)
            check("contend_order", done_order[k], (k % 2 == 0) ? 2 : 1);
        check("contend_i_cnt", i_grant_cnt, 16'd3);
        check("contend_d_cnt", d_grant_cnt, 16'd3);
        cyc = 0;
        while ((hold_i || hold_d || own != 0) && cyc < 100) begin
            agent(0, seen_i, hold_i, i_read_m, i_write_m, i_addr, i_size, i_wdata);
            agent(0, seen_d, hold_d, d_read_m, d_write_m, d_addr, d_size, d_wdata);
            mem_agent(); cycle(); cyc++;
        end
        check("drain_done", own, 0);

        // Random traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(63) == 0);
            agent(30, seen_i, hold_i, i_read_m, i_write_m, i_addr, i_size, i_wdata);
            agent(30, seen_d, hold_d, d_read_m, d_write_m, d_addr, d_size, d_wdata);
            mem_agent(); cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
